load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_WORDS, default 3101; number of 32-bit words in the downstream data memory.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  pipeline presents a memory request.
REQ-005 req_ready  output  1  unit can accept a request this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-008 req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 mem_addr  output  32  word index to data memory (captured byte address >> 2).
REQ-012 mem_wdata  output  32  word written to data memory.
REQ-013 mem_write  output  1  data-memory write strobe.
REQ-014 mem_read  output  1  data-memory read strobe.
REQ-015 mem_rdata  input  32  data-memory read word, valid combinationally while mem_read=1 and mem_write=0.
REQ-016 resp_valid  output  1  one-cycle pulse; request complete.
REQ-017 resp_rdata  output  32  extended load result; 0 for stores and errors.
REQ-018 resp_err  output  1  qualified by resp_valid; request rejected, no memory access made.

Function
REQ-019 FSM states SHALL be IDLE, READ, WRITE, RESP.
REQ-020 req_ready SHALL be 1 only in IDLE; a request is accepted when req_valid=1 and req_ready=1; all request fields are captured on acceptance.
REQ-021 Error if req_size=11, or halfword with addr[0]=1, or word with addr[1:0]!=00, or (addr>>2) >= MEM_WORDS; on error IDLE->RESP with resp_err=1 and no mem strobe.
REQ-022 Load (legal): IDLE->READ->RESP; mem_read=1 during READ only; mem_rdata sampled at end of READ.
REQ-023 Word store: IDLE->WRITE->RESP; mem_write=1 during WRITE only; mem_wdata=captured wdata.
REQ-024 Byte/halfword store: IDLE->READ->WRITE->RESP (read-modify-write); read word latched in READ; in WRITE mem_wdata = latched word with only the addressed lane(s) replaced by wdata[7:0] at byte lane addr[1:0], or wdata[15:0] at half lane addr[1].
REQ-025 mem_read and mem_write SHALL never be 1 in the same cycle; both 0 in IDLE and RESP.
REQ-026 mem_addr SHALL hold the captured word index from acceptance through RESP; 0 in IDLE.
REQ-027 Load extraction: byte = lane addr[1:0], half = lane addr[1] (lane 0 = bits [7:0]); extend per req_unsigned; word unchanged.
REQ-028 resp_valid=1 for exactly the RESP cycle; RESP->IDLE unconditionally (no backpressure).
REQ-029 Latency accept-to-resp_valid: error 1 cycle, load 2, word store 2, sub-word store 3.
REQ-030 A new request SHALL be accepted no earlier than the cycle after RESP; req_valid outside IDLE is ignored and not queued.
REQ-031 Request inputs changing after acceptance SHALL not affect the in-flight operation.

Reset
REQ-032 While rst_n=0 at a rising edge: state=IDLE, all captured registers=0, req_ready=1 after the edge, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset in any state aborts the operation; no resp_valid is issued for it and a write in the WRITE cycle coinciding with reset SHALL be suppressed (mem_write driven 0).

Verification
REQ-034 Word store addr=0x10, wdata=0xDEADBEEF, then word load 0x10 -> mem word 4 = 0xDEADBEEF; load resp_rdata=0xDEADBEEF, resp_err=0, 2-cycle latency each.
REQ-035 Word 4 = 0x11223344; byte store addr=0x12, wdata=0xAA -> word 4 = 0x11AA3344 after 3-cycle latency; no cycle with both strobes high.
REQ-036 Word 4 = 0x80FF7F01; signed byte load 0x13 -> 0xFFFFFF80; unsigned byte 0x13 -> 0x00000080; signed half 0x10 -> 0x00007F01; signed half 0x12 -> 0xFFFF80FF.
REQ-037 Half load addr=0x11, word store addr=0x02, size=11, word load addr=4*3101 -> each resp_err=1, resp_rdata=0, 1-cycle latency, mem_read=mem_write=0 throughout.
REQ-038 Sub-word store accepted, rst_n=0 in WRITE cycle -> mem_write=0, memory unchanged, no resp_valid, req_ready=1 after reset release.
REQ-039 req_valid held high continuously with back-to-back loads -> one acceptance per completed request, resp_valid pulses single-cycle, req_ready low outside IDLE.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request, response and data-memory signals of the load/store unit.
// The unit itself connects through the slave modport.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsigned, req_addr, req_wdata,
    input  mem_rdata,
    output req_ready,
    output mem_addr, mem_wdata,
    output mem_write, mem_read,
    output resp_valid, resp_rdata, resp_err
  );

  modport master (
    output req_valid, req_we, req_size,
    output req_unsigned, req_addr, req_wdata,
    output mem_rdata,
    input  req_ready,
    input  mem_addr, mem_wdata,
    input  mem_write, mem_read,
    input  resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with alignment checks,
// sign/zero extension and read-modify-write for sub-word stores.
module load_store_unit #(
  parameter int unsigned MEM_WORDS = 3101
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } state_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [29:0] WORDS = 30'(MEM_WORDS);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        uns_q, uns_d;
  logic        err_q, err_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word_q, word_d;

  logic        req_err;
  logic        resp_v;
  logic [4:0]  lane_sh;
  logic [4:0]  half_sh;
  logic [31:0] lane_w;
  logic [31:0] ext;
  logic [31:0] mask;
  logic [31:0] merged;

  always_comb begin
    req_err = 1'b0;
    unique case (bus.req_size)
      SZ_B:    req_err = 1'b0;
      SZ_H:    req_err = bus.req_addr[0];
      SZ_W:    req_err = |bus.req_addr[1:0];
      default: req_err = 1'b1;
    endcase
    if (bus.req_addr[31:2] >= WORDS) begin
      req_err = 1'b1;
    end
  end

  assign lane_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};
  assign lane_w  = word_q >> lane_sh;

  always_comb begin
    ext = word_q;
    unique case (size_q)
      SZ_B: ext = uns_q ? {24'h0, lane_w[7:0]}
                        : {{24{lane_w[7]}}, lane_w[7:0]};
      SZ_H: ext = uns_q ? {16'h0, lane_w[15:0]}
                        : {{16{lane_w[15]}}, lane_w[15:0]};
      default: ext = word_q;
    endcase
  end

  // Sub-word stores splice the new lane into the word read back in READ.
  always_comb begin
    mask   = '0;
    merged = wdata_q;
    unique case (size_q)
      SZ_B: begin
        mask   = 32'h0000_00FF << lane_sh;
        merged = (word_q & ~mask)
               | ({4{wdata_q[7:0]}} & mask);
      end
      SZ_H: begin
        mask   = 32'h0000_FFFF << half_sh;
        merged = (word_q & ~mask)
               | ({2{wdata_q[15:0]}} & mask);
      end
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    uns_d   = uns_q;
    err_d   = err_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          size_d  = bus.req_size;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          err_d   = req_err;
          word_d  = '0;
          if (req_err) begin
            state_d = RESP;
          end else if (!bus.req_we || bus.req_size != SZ_W) begin
            state_d = READ;
          end else begin
            state_d = WRITE;
          end
        end
      end
      READ: begin
        word_d  = bus.mem_rdata;
        state_d = we_q ? WRITE : RESP;
      end
      WRITE: state_d = RESP;
      RESP:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
    end
  end

  // Strobes are gated by rst_n so an aborted operation has no effect.
  assign resp_v         = (state_q == RESP) && rst_n;
  assign bus.req_ready  = (state_q == IDLE);
  assign bus.mem_read   = (state_q == READ);
  assign bus.mem_write  = (state_q == WRITE) && rst_n;
  assign bus.mem_addr   = (state_q == IDLE) ? '0
                        : {2'b00, addr_q[31:2]};
  assign bus.mem_wdata  = (state_q == WRITE) ? merged : '0;
  assign bus.resp_valid = resp_v;
  assign bus.resp_err   = resp_v && err_q;
  assign bus.resp_rdata = (resp_v && !we_q && !err_q) ? ext : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural
// data memory and a reference model of the memory image.
module tb_load_store_unit;

  localparam int MW = 3101;

  typedef struct {
    string       tag;
    logic [31:0] rd;
    logic        err;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int strobes = 0;
  int n_acc = 0;
  int n_resp = 0;
  logic prev_resp = 1'b0;

  logic [31:0] mem  [MW];
  logic [31:0] refm [MW];

  exp_t exp_q[$];
  int   acc_q[$];

  load_store_unit_if bus();

  load_store_unit #(.MEM_WORDS(MW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < 32'(MW))
      mem[bus.mem_addr[11:0]] <= bus.mem_wdata;
  end

  always_comb begin
    bus.mem_rdata = 32'h0;
    if (bus.mem_addr < 32'(MW))
      bus.mem_rdata = mem[bus.mem_addr[11:0]];
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic m_err(input logic [1:0] sz,
                                 input logic [31:0] a);
    logic e;
    e = (a[31:2] >= 30'(MW));
    if (sz == 2'b11) e = 1'b1;
    if (sz == 2'b01 && a[0]) e = 1'b1;
    if (sz == 2'b10 && a[1:0] != 2'b00) e = 1'b1;
    return e;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w,
                                         input logic [1:0] sz,
                                         input logic u,
                                         input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    if (sz == 2'b00) return u ? {24'h0, b} : {{24{b[7]}}, b};
    if (sz == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return w;
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w,
                                          input logic [1:0] sz,
                                          input logic [1:0] a,
                                          input logic [31:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00) begin
      case (a)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end else if (sz == 2'b01) begin
      if (a[1]) r[31:16] = d[15:0];
      else      r[15:0]  = d[15:0];
    end else begin
      r = d;
    end
    return r;
  endfunction

  task automatic push_exp(input string tag, input logic we,
                          input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic fix, input logic [31:0] fix_rd);
    exp_t e;
    logic [11:0] idx;
    idx = a[13:2];
    e.tag = tag;
    e.err = m_err(sz, a);
    e.rd  = 32'h0;
    if (e.err) begin
      e.lat = 1;
    end else if (we) begin
      e.lat = (sz == 2'b10) ? 2 : 3;
      refm[idx] = m_store(refm[idx], sz, a[1:0], d);
    end else begin
      e.lat = 2;
      e.rd  = m_load(refm[idx], sz, u, a[1:0]);
    end
    if (fix) e.rd = fix_rd;
    exp_q.push_back(e);
  endtask

  task automatic lsu_req(input string tag, input logic we,
                         input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic fix, input logic [31:0] fix_rd);
    int n;
    n = 0;
    while (!bus.req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = u;
    bus.req_addr     = a;
    bus.req_wdata    = d;
    bus.req_valid    = 1'b1;
    push_exp(tag, we, sz, u, a, d, fix, fix_rd);
    @(posedge clk); #1;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'($urandom);
    bus.req_size     = 2'($urandom);
    bus.req_unsigned = 1'($urandom);
    bus.req_addr     = $urandom;
    bus.req_wdata    = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready) && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    int a;
    if (rst_n) begin
      if (bus.mem_read || bus.mem_write) begin
        strobes++;
        check("strobe_excl", 32'(bus.mem_read && bus.mem_write), 32'd0);
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_q.push_back(cyc);
        n_acc++;
      end
      if (bus.resp_valid) begin
        n_resp++;
        check("resp_pulse", 32'(prev_resp), 32'd0);
        check("ready_in_resp", 32'(bus.req_ready), 32'd0);
        check("resp_expected",
              32'(exp_q.size() > 0 && acc_q.size() > 0), 32'd1);
        if (exp_q.size() > 0 && acc_q.size() > 0) begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check({e.tag, "_rdata"}, bus.resp_rdata, e.rd);
          check({e.tag, "_err"}, 32'(bus.resp_err), 32'(e.err));
          check({e.tag, "_lat"}, 32'(cyc - a), 32'(e.lat));
        end
      end
      prev_resp = bus.resp_valid;
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int s0, a0, r0, n;
    logic [31:0] saved;
    logic [31:0] a, d;
    logic [1:0]  sz;
    for (int i = 0; i < MW; i++) begin
      mem[i]  = 32'(i) * 32'h9E37_79B9;
      refm[i] = 32'(i) * 32'h9E37_79B9;
    end
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_resp_err", 32'(bus.resp_err), 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'h0);
    check("rst_mem_read", 32'(bus.mem_read), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    lsu_req("sw_dead", 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF, 0, 0);
    lsu_req("lw_dead", 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'hDEAD_BEEF);
    drain();
    check("mem4_dead", mem[4], 32'hDEAD_BEEF);

    lsu_req("sw_1122", 1, 2'b10, 0, 32'h10, 32'h1122_3344, 0, 0);
    lsu_req("sb_aa", 1, 2'b00, 0, 32'h12, 32'h0000_00AA, 0, 0);
    drain();
    check("mem4_rmw", mem[4], 32'h11AA_3344);

    lsu_req("sw_80ff", 1, 2'b10, 0, 32'h10, 32'h80FF_7F01, 0, 0);
    lsu_req("lb_s13", 0, 2'b00, 0, 32'h13, 32'h0, 1, 32'hFFFF_FF80);
    lsu_req("lb_u13", 0, 2'b00, 1, 32'h13, 32'h0, 1, 32'h0000_0080);
    lsu_req("lh_s10", 0, 2'b01, 0, 32'h10, 32'h0, 1, 32'h0000_7F01);
    lsu_req("lh_s12", 0, 2'b01, 0, 32'h12, 32'h0, 1, 32'hFFFF_80FF);
    drain();

    s0 = strobes;
    lsu_req("err_lh11", 0, 2'b01, 0, 32'h11, 32'h0, 0, 0);
    lsu_req("err_sw02", 1, 2'b10, 0, 32'h02, 32'h1234_5678, 0, 0);
    lsu_req("err_sz3", 0, 2'b11, 0, 32'h20, 32'h0, 0, 0);
    lsu_req("err_oob", 0, 2'b10, 0, 32'(4 * MW), 32'h0, 0, 0);
    drain();
    check("err_no_strobe", 32'(strobes - s0), 32'd0);
    check("err_mem0", mem[0], refm[0]);

    lsu_req("sw_w8", 1, 2'b10, 0, 32'h20, 32'hCAFE_F00D, 0, 0);
    drain();
    saved = refm[8];
    lsu_req("rst_sb", 1, 2'b00, 0, 32'h21, 32'h55, 0, 0);
    n = 0;
    while (!bus.mem_write && n < 10) begin
      @(negedge clk); n++;
    end
    check("rst_reach_write", 32'(bus.mem_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_wr_suppress", 32'(bus.mem_write), 32'd0);
    exp_q.delete();
    acc_q.delete();
    refm[8] = saved;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_rel_ready", 32'(bus.req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    check("rst_mem8", mem[8], 32'hCAFE_F00D);

    a0 = n_acc;
    r0 = n_resp;
    bus.req_we       = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 32'h10;
    bus.req_valid    = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      while (!bus.req_ready && n < 20) begin
        @(posedge clk); #1; n++;
      end
      check("b2b_ready", 32'(bus.req_ready), 32'd1);
      push_exp("b2b", 0, 2'b10, 0, 32'h10, 32'h0, 1, 32'h80FF_7F01);
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    drain();
    check("b2b_acc", 32'(n_acc - a0), 32'd5);
    check("b2b_resp", 32'(n_resp - r0), 32'd5);

    for (int k = 0; k < 24; k++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 7)) * 4;
      if (sz == 2'b00) a = a + 32'($urandom_range(0, 3));
      if (sz == 2'b01) a = a + 32'($urandom_range(0, 1)) * 2;
      d  = $urandom;
      lsu_req("rnd", 1'($urandom), sz, 1'($urandom), a, d, 0, 0);
    end
    drain();
    for (int i = 0; i < 8; i++) begin
      check("rnd_mem", mem[i], refm[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
